// File: rtl/load_store_unit.sv
// Byte-addressed RV32 load/store front end for a word-addressed memory.
// Sub-word stores read-modify-write; word-crossing accesses split into two words.
module load_store_unit #(
  parameter int MEMORY_DEPTH = 1024,
  parameter int MEMORY_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic                    resp_error,
  output logic [31:0]             resp_rdata,
  output logic [31:0]             mem_addr,
  output logic [MEMORY_WIDTH-1:0] mem_write_data,
  output logic                    mem_write_enable,
  input  logic [MEMORY_WIDTH-1:0] mem_read_data
);

  localparam int AW = $clog2(MEMORY_DEPTH);

  typedef enum logic [3:0] {
    IDLE, LD0, LD1, ST0R, ST0W, ST1R, ST1W, RESP, ERR
  } state_t;

  state_t r_state, w_next;

  logic          r_we;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_buf0;
  logic [31:0]   r_buf1;
  logic [31:0]   r_merged;

  logic [1:0]    w_off;
  logic [AW-1:0] w_word0;
  logic [AW-1:0] w_word1;
  logic [2:0]    w_size;
  logic          w_cross;
  logic          w_aligned_sw;
  logic          w_req_legal;
  logic [31:0]   w_sizemask;
  logic [63:0]   w_mask64;
  logic [63:0]   w_data64;
  logic [31:0]   w_merge_lo;
  logic [31:0]   w_merge_hi;
  logic [31:0]   w_load;
  logic [31:0]   w_load_ext;
  logic          w_unused_addr;

  assign w_off        = r_addr[1:0];
  assign w_word0      = r_addr[AW+1:2];
  assign w_word1      = w_word0 + AW'(1);
  assign w_unused_addr = ^r_addr[31:AW+2];

  always_comb begin
    w_size     = 3'd4;
    w_sizemask = 32'hFFFF_FFFF;
    case (r_funct3[1:0])
      2'b00: begin w_size = 3'd1; w_sizemask = 32'h0000_00FF; end
      2'b01: begin w_size = 3'd2; w_sizemask = 32'h0000_FFFF; end
      default: ;
    endcase
  end

  assign w_cross      = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_aligned_sw = (r_funct3 == 3'b010) && (w_off == 2'b00);

  assign w_req_legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

  // Store bytes and lane mask placed in the 8-byte window {word1, word0}
  assign w_mask64   = {32'b0, w_sizemask} << {w_off, 3'b000};
  assign w_data64   = {32'b0, r_wdata} << {w_off, 3'b000};
  assign w_merge_lo = (mem_read_data & ~w_mask64[31:0])  | (w_data64[31:0]  & w_mask64[31:0]);
  assign w_merge_hi = (mem_read_data & ~w_mask64[63:32]) | (w_data64[63:32] & w_mask64[63:32]);

  assign w_load = 32'({r_buf1, r_buf0} >> {w_off, 3'b000});

  always_comb begin
    w_load_ext = w_load;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_load[7]}}, w_load[7:0]};
      3'b001:  w_load_ext = {{16{w_load[15]}}, w_load[15:0]};
      3'b100:  w_load_ext = {24'b0, w_load[7:0]};
      3'b101:  w_load_ext = {16'b0, w_load[15:0]};
      default: w_load_ext = w_load;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buf0   <= '0;
      r_buf1   <= '0;
      r_merged <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_funct3 <= req_funct3;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
        end
        LD0:  r_buf0   <= mem_read_data;
        LD1:  r_buf1   <= mem_read_data;
        ST0R: r_merged <= w_merge_lo;
        ST1R: r_merged <= w_merge_hi;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    resp_rdata       = '0;
    mem_addr         = 32'(w_word0);
    mem_write_data   = r_merged;
    mem_write_enable = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!w_req_legal)                                        w_next = ERR;
          else if (!req_we)                                        w_next = LD0;
          else if (req_funct3 == 3'b010 && req_addr[1:0] == 2'b00) w_next = ST0W;
          else                                                     w_next = ST0R;
        end
      end
      LD0:  w_next = w_cross ? LD1 : RESP;
      LD1: begin
        mem_addr = 32'(w_word1);
        w_next   = RESP;
      end
      ST0R: w_next = ST0W;
      ST0W: begin
        mem_write_enable = !rst;
        mem_write_data   = w_aligned_sw ? r_wdata : r_merged;
        w_next           = w_cross ? ST1R : RESP;
      end
      ST1R: begin
        mem_addr = 32'(w_word1);
        w_next   = ST1W;
      end
      ST1W: begin
        mem_addr         = 32'(w_word1);
        mem_write_enable = !rst;
        w_next           = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_we ? 32'b0 : w_load_ext;
        w_next     = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_error = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word memory model, hand-computed vectors.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          wr_count = 0;
  logic [31:0] wr_last = '0, wr_prev = '0;
  logic [31:0] trace [0:31];

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.MEMORY_DEPTH(1024), .MEMORY_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write_enable) begin
      mem[mem_addr[9:0]] <= mem_write_data;
      wr_prev  <= wr_last;
      wr_last  <= mem_addr;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called one step after the accept edge (cycle 1); returns the response cycle.
  task automatic wait_resp(output int cyc, output logic [31:0] rd, output logic er);
    cyc = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      trace[n] = mem_addr;
      if (resp_valid) begin
        cyc = n; rd = resp_rdata; er = resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    if (cyc == 0) chk("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output int cyc, output logic [31:0] rd,
                      output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // scramble request fields after accept; the DUT must use its captured copy
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = $urandom; req_wdata = $urandom;
    wait_resp(cyc, rd, er);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp, input int exp_cyc);
    int cyc; logic [31:0] rd; logic er; int w0;
    w0 = wr_count;
    xact(1'b0, f3, addr, 32'h0, cyc, rd, er);
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_err"}, 32'(er), 32'd0);
    chk({tag, "_writes"}, 32'(wr_count - w0), 32'd0);
  endtask

  initial begin
    int cyc; logic [31:0] rd; logic er; int w0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_error", 32'(resp_error), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);

    preload(10'd4, 32'h4433_2211);
    preload(10'd5, 32'h8877_6655);
    run_load("lb13",  3'b000, 32'h13, 32'h0000_0044, 2);
    run_load("lb17",  3'b000, 32'h17, 32'hFFFF_FF88, 2);
    run_load("lbu17", 3'b100, 32'h17, 32'h0000_0088, 2);
    run_load("lh16",  3'b001, 32'h16, 32'hFFFF_8877, 2);
    run_load("lhu16", 3'b101, 32'h16, 32'h0000_8877, 2);
    run_load("lh13",  3'b001, 32'h13, 32'h0000_5544, 3);
    run_load("lw12",  3'b010, 32'h12, 32'h6655_4433, 3);
    chk("lw12_addr0", trace[1], 32'd4);
    chk("lw12_addr1", trace[2], 32'd5);
    run_load("lw10",  3'b010, 32'h10, 32'h4433_2211, 2);

    w0 = wr_count;
    xact(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAB, cyc, rd, er);
    chk("sb11_mem4", mem[4], 32'h4433_AB11);
    chk("sb11_cycle", 32'(cyc), 32'd3);
    chk("sb11_writes", 32'(wr_count - w0), 32'd1);
    chk("sb11_rdata", rd, 32'h0);

    preload(10'd4, 32'h4433_2211);
    w0 = wr_count;
    xact(1'b1, 3'b001, 32'h13, 32'h0000_BEEF, cyc, rd, er);
    chk("sh13_mem4", mem[4], 32'hEF33_2211);
    chk("sh13_mem5", mem[5], 32'h8877_66BE);
    chk("sh13_writes", 32'(wr_count - w0), 32'd2);
    chk("sh13_cycle", 32'(cyc), 32'd5);
    chk("sh13_err", 32'(er), 32'd0);

    w0 = wr_count;
    xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, cyc, rd, er);
    chk("sw10_mem4", mem[4], 32'hDEAD_BEEF);
    chk("sw10_writes", 32'(wr_count - w0), 32'd1);
    chk("sw10_waddr", wr_last, 32'd4);
    chk("sw10_cycle", 32'(cyc), 32'd2);

    preload(10'd1023, 32'hDDCC_BBAA);
    preload(10'd0,    32'h4433_2211);
    run_load("lwFFE", 3'b010, 32'hFFE, 32'h2211_DDCC, 3);
    chk("lwFFE_addr0", trace[1], 32'd1023);
    chk("lwFFE_addr1", trace[2], 32'd0);
    w0 = wr_count;
    xact(1'b1, 3'b010, 32'hFFD, 32'h1234_5678, cyc, rd, er);
    chk("swFFD_mem1023", mem[1023], 32'h3456_78AA);
    chk("swFFD_mem0", mem[0], 32'h4433_2212);
    chk("swFFD_first", wr_prev, 32'd1023);
    chk("swFFD_second", wr_last, 32'd0);
    chk("swFFD_cycle", 32'(cyc), 32'd5);
    chk("swFFD_writes", 32'(wr_count - w0), 32'd2);

    w0 = wr_count;
    xact(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, cyc, rd, er);
    chk("ill_st_err", 32'(er), 32'd1);
    chk("ill_st_cycle", 32'(cyc), 32'd1);
    chk("ill_st_rdata", rd, 32'h0);
    chk("ill_st_writes", 32'(wr_count - w0), 32'd0);
    xact(1'b0, 3'b110, 32'h10, 32'h0, cyc, rd, er);
    chk("ill_ld_err", 32'(er), 32'd1);
    chk("ill_ld_cycle", 32'(cyc), 32'd1);

    // Back-to-back: second request held valid while the first is in flight
    preload(10'd5, 32'h8877_6655);
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = '0;
    @(posedge clk); #1;
    req_we = 1'b1; req_funct3 = 3'b000; req_wdata = 32'h0000_00FF;
    chk("b2b_busy_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b_resp1", 32'(resp_valid), 32'd1);
    chk("b2b_rdata1", resp_rdata, 32'h8877_6655);
    chk("b2b_resp_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    chk("b2b_no_early_write", 32'(wr_count - w0), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(cyc, rd, er);
    @(posedge clk); #1;
    chk("b2b_cycle2", 32'(cyc), 32'd3);
    chk("b2b_mem5", mem[5], 32'h8877_66FF);
    chk("b2b_writes", 32'(wr_count - w0), 32'd1);

    // Reset during ST1W of a crossing sh
    preload(10'd4, 32'h4433_2211);
    preload(10'd5, 32'h8877_6655);
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h13; req_wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_at_st1w", 32'(mem_write_enable), 32'd1);
    chk("rst_addr_w1", mem_addr, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_writes", 32'(wr_count - w0), 32'd1);
    chk("rst_mid_mem4", mem[4], 32'hEF33_2211);
    chk("rst_mid_mem5", mem[5], 32'h8877_6655);
    @(posedge clk); #1;
    chk("rst_mid_valid2", 32'(resp_valid), 32'd0);
    run_load("post_rst_lw10", 3'b010, 32'h10, 32'hEF33_2211, 2);
    run_load("post_rst_lw14", 3'b010, 32'h14, 32'h8877_6655, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
